// File: rtl/prach_pkg.sv
// Shared types, constants and rounding helper for the PRACH 3-point DFT blocks.
package prach_pkg;

    localparam int unsigned DW = 18;
    localparam int unsigned VW = 24;
    localparam int unsigned PW = 40;

    localparam logic signed [DW-1:0] C3_SQRT3_HALF = 18'sd113511;
    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef struct packed {
        logic signed [DW-1:0] dr;
        logic signed [DW-1:0] di;
    } cplx_t;

    typedef struct packed {
        logic signed [DW:0] r;
        logic signed [DW:0] i;
    } c19_t;

    typedef struct packed {
        logic signed [VW-1:0] r;
        logic signed [VW-1:0] i;
    } cw_t;

    typedef struct packed {
        logic signed [PW-1:0] r;
        logic signed [PW-1:0] i;
    } cp_t;

    typedef enum logic [1:0] {UNSYNCED, C0, C1, C2} frame_state_t;

    // Round-half-up right shift by (shift+1), then clamp to the 18-bit range.
    function automatic logic signed [DW-1:0] sat_round(input logic signed [VW-1:0] v,
                                                       input int unsigned shift);
        logic signed [VW-1:0] r;
        r = (v + (VW'(1) <<< shift)) >>> (shift + 1);
        if (r > VW'(SAT_MAX)) return SAT_MAX;
        if (r < VW'(SAT_MIN)) return SAT_MIN;
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/prach_ditifft3_core.sv
// 3-point inverse DFT datapath: five register stages from captured X0..X2 to rounded x0..x2.
module prach_ditifft3_core
    import prach_pkg::*;
#(
    parameter int unsigned Shift = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2*DW-1:0] x0_i,
    input  logic [2*DW-1:0] x1_i,
    input  logic [2*DW-1:0] x2_i,
    output logic            valid_o,
    output logic [2*DW-1:0] y0_o,
    output logic [2*DW-1:0] y1_o,
    output logic [2*DW-1:0] y2_o
);
    localparam logic signed [PW-1:0] RND_HALF = PW'(32768);

    cplx_t      a0, a1, a2;
    c19_t       t_d, d_d, dx0_d, t_q, d_q, dx0_q;
    cw_t        v0a_d, m2a_d, v0a_q, m2a_q;
    cp_t        p_d, p_q;
    cw_t        s2_d, v0b_q, m2b_q, s2_q;
    cw_t        v1_d, v2_d, v0c_q, v1_q, v2_q;
    cplx_t      y0_d, y1_d, y2_d, y0_q, y1_q, y2_q;
    logic [4:0] vld_q;

    assign a0 = x0_i;
    assign a1 = x1_i;
    assign a2 = x2_i;

    always_comb begin
        t_d.r   = (DW+1)'(a1.dr) + (DW+1)'(a2.dr);
        t_d.i   = (DW+1)'(a1.di) + (DW+1)'(a2.di);
        d_d.r   = (DW+1)'(a1.dr) - (DW+1)'(a2.dr);
        d_d.i   = (DW+1)'(a1.di) - (DW+1)'(a2.di);
        dx0_d.r = (DW+1)'(a0.dr) <<< 1;
        dx0_d.i = (DW+1)'(a0.di) <<< 1;

        v0a_d.r = VW'(dx0_q.r) + (VW'(t_q.r) <<< 1);
        v0a_d.i = VW'(dx0_q.i) + (VW'(t_q.i) <<< 1);
        m2a_d.r = VW'(dx0_q.r) - VW'(t_q.r);
        m2a_d.i = VW'(dx0_q.i) - VW'(t_q.i);
        // j*d*C: the real part takes -Im(d), the imaginary part takes +Re(d).
        p_d.r   = -(PW'(d_q.i) * PW'(C3_SQRT3_HALF));
        p_d.i   = PW'(d_q.r) * PW'(C3_SQRT3_HALF);

        s2_d.r  = VW'((p_q.r + RND_HALF) >>> 16);
        s2_d.i  = VW'((p_q.i + RND_HALF) >>> 16);

        v1_d.r  = m2b_q.r + s2_q.r;
        v1_d.i  = m2b_q.i + s2_q.i;
        v2_d.r  = m2b_q.r - s2_q.r;
        v2_d.i  = m2b_q.i - s2_q.i;

        y0_d.dr = sat_round(v0c_q.r, Shift);
        y0_d.di = sat_round(v0c_q.i, Shift);
        y1_d.dr = sat_round(v1_q.r, Shift);
        y1_d.di = sat_round(v1_q.i, Shift);
        y2_d.dr = sat_round(v2_q.r, Shift);
        y2_d.di = sat_round(v2_q.i, Shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            t_q   <= '0;
            d_q   <= '0;
            dx0_q <= '0;
            v0a_q <= '0;
            m2a_q <= '0;
            p_q   <= '0;
            v0b_q <= '0;
            m2b_q <= '0;
            s2_q  <= '0;
            v0c_q <= '0;
            v1_q  <= '0;
            v2_q  <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
        end else begin
            vld_q <= {vld_q[3:0], start_i};
            t_q   <= t_d;
            d_q   <= d_d;
            dx0_q <= dx0_d;
            v0a_q <= v0a_d;
            m2a_q <= m2a_d;
            p_q   <= p_d;
            v0b_q <= v0a_q;
            m2b_q <= m2a_q;
            s2_q  <= s2_d;
            v0c_q <= v0b_q;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
        end
    end

    assign valid_o = vld_q[4];
    assign y0_o    = y0_q;
    assign y1_o    = y1_q;
    assign y2_o    = y2_q;

endmodule

// File: rtl/prach_ditifft3.sv
// Streaming 3-point inverse DFT: sync-framed capture, pipelined math core, 3-cycle output burst.
module prach_ditifft3
    import prach_pkg::*;
#(
    parameter int unsigned Shift = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din_dr,
    input  logic [DW-1:0] din_di,
    input  logic          din_dv,
    input  logic          sync_in,
    output logic [DW-1:0] dout_dr,
    output logic [DW-1:0] dout_di,
    output logic          dout_dv,
    output logic          sync_out
);
    frame_state_t    state_q;
    cplx_t           x0_q, x1_q, x2_q;
    logic            go_q;
    logic            cv;
    logic [2*DW-1:0] cy0, cy1, cy2;
    cplx_t           dout_q, h1_q, h2_q;
    logic            dv_q, sync_q;
    logic [1:0]      rem_q;

    // A sync always restarts framing, discarding any partially captured frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSYNCED;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            go_q    <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (din_dv) begin
                if (sync_in) begin
                    x0_q    <= {din_dr, din_di};
                    state_q <= C1;
                end else begin
                    case (state_q)
                        C0: begin
                            x0_q    <= {din_dr, din_di};
                            state_q <= C1;
                        end
                        C1: begin
                            x1_q    <= {din_dr, din_di};
                            state_q <= C2;
                        end
                        C2: begin
                            x2_q    <= {din_dr, din_di};
                            go_q    <= 1'b1;
                            state_q <= C0;
                        end
                        default: state_q <= UNSYNCED;
                    endcase
                end
            end
        end
    end

    prach_ditifft3_core #(
        .Shift(Shift)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(go_q),
        .x0_i   (x0_q),
        .x1_i   (x1_q),
        .x2_i   (x2_q),
        .valid_o(cv),
        .y0_o   (cy0),
        .y1_o   (cy1),
        .y2_o   (cy2)
    );

    // Bursts are at least 3 cycles apart, so a new result never arrives while rem_q != 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
            dv_q   <= 1'b0;
            sync_q <= 1'b0;
            rem_q  <= '0;
        end else if (cv) begin
            dout_q <= cy0;
            h1_q   <= cy1;
            h2_q   <= cy2;
            dv_q   <= 1'b1;
            sync_q <= 1'b1;
            rem_q  <= 2'd2;
        end else if (rem_q != 2'd0) begin
            dout_q <= h1_q;
            h1_q   <= h2_q;
            dv_q   <= 1'b1;
            sync_q <= 1'b0;
            rem_q  <= rem_q - 2'd1;
        end else begin
            dout_q <= '0;
            dv_q   <= 1'b0;
            sync_q <= 1'b0;
        end
    end

    assign dout_dr  = dout_q.dr;
    assign dout_di  = dout_q.di;
    assign dout_dv  = dv_q;
    assign sync_out = sync_q;

endmodule

// File: tb/tb_prach_ditifft3.sv
// Bench for prach_ditifft3: Shift=2 and Shift=0 instances on a shared stimulus, scoreboard plus vector table.
module tb_prach_ditifft3;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [17:0] din_dr, din_di;
    logic din_dv, sync_in;
    logic signed [17:0] a_dr, a_di, b_dr, b_di;
    logic a_dv, a_sync, b_dv, b_sync;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prach_ditifft3 #(.Shift(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .dout_dr(a_dr), .dout_di(a_di), .dout_dv(a_dv), .sync_out(a_sync)
    );

    prach_ditifft3 #(.Shift(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .dout_dr(b_dr), .dout_di(b_di), .dout_dv(b_dv), .sync_out(b_sync)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     cyc;
        logic   sy;
        longint r2, i2, r0, i0;
    } exp_t;

    exp_t   expq[$];
    exp_t   mon_e;
    bit     synced = 0;
    int     idx = 0;
    longint fr_r[3], fr_i[3];

    function automatic longint rsat(input longint v, input int s);
        longint r;
        r = (v + (64'sd1 <<< s)) >>> (s + 1);
        if (r > 131071) r = 131071;
        if (r < -131072) r = -131072;
        return r;
    endfunction

    // x_n = sum_k X_k * W^(nk), W = exp(+j*2*pi/3), with the sqrt(3)/2 term rounded to 1 fractional bit
    function automatic void idft(input longint xr[3], input longint xi[3], input int s,
                                 output longint yr[3], output longint yi[3]);
        longint tr, ti, dr, di, s2r, s2i, m2r, m2i;
        tr  = xr[1] + xr[2];
        ti  = xi[1] + xi[2];
        dr  = xr[1] - xr[2];
        di  = xi[1] - xi[2];
        s2r = (-di * 113511 + 32768) >>> 16;
        s2i = (dr * 113511 + 32768) >>> 16;
        m2r = 2 * xr[0] - tr;
        m2i = 2 * xi[0] - ti;
        yr[0] = rsat(2 * (xr[0] + tr), s);
        yi[0] = rsat(2 * (xi[0] + ti), s);
        yr[1] = rsat(m2r + s2r, s);
        yi[1] = rsat(m2i + s2i, s);
        yr[2] = rsat(m2r - s2r, s);
        yi[2] = rsat(m2i - s2i, s);
    endfunction

    function automatic void model_take(input logic sy, input longint r, input longint i);
        longint yr2[3], yi2[3], yr0[3], yi0[3];
        exp_t   ent;
        if (sy) begin
            synced = 1;
            idx = 0;
        end
        if (synced) begin
            fr_r[idx] = r;
            fr_i[idx] = i;
            idx++;
            if (idx == 3) begin
                idx = 0;
                idft(fr_r, fr_i, 2, yr2, yi2);
                idft(fr_r, fr_i, 0, yr0, yi0);
                for (int k = 0; k < 3; k++) begin
                    ent.cyc = cyc + 7 + k;
                    ent.sy  = (k == 0);
                    ent.r2  = yr2[k];
                    ent.i2  = yi2[k];
                    ent.r0  = yr0[k];
                    ent.i0  = yi0[k];
                    expq.push_back(ent);
                end
            end
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            mon_e = expq.pop_front();
            chk("sb_dv_s2", longint'(a_dv), 1);
            chk("sb_dv_s0", longint'(b_dv), 1);
            chk("sb_sync_s2", longint'(a_sync), longint'(mon_e.sy));
            chk("sb_sync_s0", longint'(b_sync), longint'(mon_e.sy));
            chk("sb_re_s2", longint'(a_dr), mon_e.r2);
            chk("sb_im_s2", longint'(a_di), mon_e.i2);
            chk("sb_re_s0", longint'(b_dr), mon_e.r0);
            chk("sb_im_s0", longint'(b_di), mon_e.i0);
        end else begin
            chk("sb_idle_dv", longint'({a_dv, b_dv}), 0);
            chk("sb_idle_sync", longint'({a_sync, b_sync}), 0);
            chk("sb_idle_data", longint'({a_dr, a_di, b_dr, b_di}), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic dv, input logic sy, input logic signed [17:0] r,
                        input logic signed [17:0] i);
        din_dv  = dv;
        sync_in = sy;
        din_dr  = r;
        din_di  = i;
        if (dv && rst_n) model_take(sy, longint'(r), longint'(i));
        @(posedge clk);
        #1;
    endtask

    task automatic step_idle();
        step(1'b0, 1'b0, 18'sd0, 18'sd0);
    endtask

    function automatic logic signed [17:0] rnd_sample();
        case ($urandom_range(0, 5))
            0: return 18'sh1FFFF;
            1: return 18'sh20000;
            2: return 18'($urandom_range(0, 2000)) - 18'sd1000;
            default: return 18'($urandom);
        endcase
    endfunction

    typedef struct {
        int x[6];
        int e2[6];
        int e0[6];
    } vec_t;

    vec_t vt[4];
    int   cnt_dv, cnt_sy, first;
    logic dvh[20], syh[20];

    initial begin
        vt[0].x  = '{1000, 0, 0, 0, 0, 0};
        vt[0].e2 = '{250, 0, 250, 0, 250, 0};
        vt[0].e0 = '{1000, 0, 1000, 0, 1000, 0};
        vt[1].x  = '{0, 0, 4000, 0, 0, 0};
        vt[1].e2 = '{1000, 0, -500, 866, -500, -866};
        vt[1].e0 = '{4000, 0, -2000, 3464, -2000, -3464};
        vt[2].x  = '{131071, 131071, 131071, 131071, 131071, 131071};
        vt[2].e2 = '{98303, 98303, 0, 0, 0, 0};
        vt[2].e0 = '{131071, 131071, 0, 0, 0, 0};
        vt[3].x  = '{-131072, -131072, -131072, -131072, -131072, -131072};
        vt[3].e2 = '{-98304, -98304, 0, 0, 0, 0};
        vt[3].e0 = '{-131072, -131072, 0, 0, 0, 0};

        rst_n = 1'b0;
        din_dv = 1'b0;
        sync_in = 1'b0;
        din_dr = '0;
        din_di = '0;
        #3;
        chk("rst_dv", longint'({a_dv, b_dv}), 0);
        chk("rst_sync", longint'({a_sync, b_sync}), 0);
        chk("rst_data", longint'({a_dr, a_di, b_dr, b_di}), 0);
        @(posedge clk);
        #1;
        step_idle();
        rst_n = 1'b1;
        step_idle();

        // directed vectors: impulse, single bin, positive/negative saturation
        for (int v = 0; v < 4; v++) begin
            step(1'b1, 1'b1, 18'(vt[v].x[0]), 18'(vt[v].x[1]));
            step(1'b1, 1'b0, 18'(vt[v].x[2]), 18'(vt[v].x[3]));
            step(1'b1, 1'b0, 18'(vt[v].x[4]), 18'(vt[v].x[5]));
            repeat (5) step_idle();
            chk("tab_lat_early", longint'(a_dv), 0);
            for (int k = 0; k < 3; k++) begin
                step_idle();
                chk("tab_dv", longint'(a_dv), 1);
                chk("tab_sync", longint'(a_sync), longint'(k == 0));
                chk("tab_re_s2", longint'(a_dr), longint'(vt[v].e2[2*k]));
                chk("tab_im_s2", longint'(a_di), longint'(vt[v].e2[2*k+1]));
                chk("tab_re_s0", longint'(b_dr), longint'(vt[v].e0[2*k]));
                chk("tab_im_s0", longint'(b_di), longint'(vt[v].e0[2*k+1]));
            end
            repeat (2) step_idle();
        end

        // continuous stream: 9 samples, one sync
        for (int i = 0; i < 20; i++) begin
            if (i < 9) step(1'b1, i == 0, rnd_sample(), rnd_sample());
            else step_idle();
            dvh[i] = a_dv;
            syh[i] = a_sync;
        end
        for (int i = 0; i < 20; i++) begin
            chk("stream_dv", longint'(dvh[i]), longint'(i >= 8 && i <= 16));
            chk("stream_sync", longint'(syh[i]), longint'(i == 8 || i == 11 || i == 14));
        end

        // resync on 2nd sample: only the restarted frame produces output
        step(1'b1, 1'b1, rnd_sample(), rnd_sample());
        step(1'b1, 1'b0, rnd_sample(), rnd_sample());
        step(1'b1, 1'b1, rnd_sample(), rnd_sample());
        step(1'b1, 1'b0, rnd_sample(), rnd_sample());
        step(1'b1, 1'b0, rnd_sample(), rnd_sample());
        cnt_dv = 0;
        cnt_sy = 0;
        for (int j = 0; j < 10; j++) begin
            step_idle();
            cnt_dv += int'(a_dv);
            cnt_sy += int'(a_sync);
        end
        chk("resync_burst_len", cnt_dv, 3);
        chk("resync_sync_cnt", cnt_sy, 1);

        // dv gaps inside a frame
        step(1'b1, 1'b1, rnd_sample(), rnd_sample());
        repeat (2) step_idle();
        step(1'b1, 1'b0, rnd_sample(), rnd_sample());
        repeat (2) step_idle();
        step(1'b1, 1'b0, rnd_sample(), rnd_sample());
        first = -1;
        for (int j = 1; j <= 10; j++) begin
            step_idle();
            if (a_dv && first < 0) first = j;
        end
        chk("gap_latency", first, 6);

        // reset while x1 is on the output
        step(1'b1, 1'b1, 18'sd3000, 18'sd0);
        step(1'b1, 1'b0, 18'sd0, 18'sd0);
        step(1'b1, 1'b0, 18'sd0, 18'sd0);
        repeat (7) step_idle();
        chk("pre_rst_dv", longint'(a_dv), 1);
        #1;
        rst_n = 1'b0;
        expq.delete();
        synced = 0;
        idx = 0;
        #1;
        chk("rst_mid_dv", longint'({a_dv, b_dv}), 0);
        chk("rst_mid_data", longint'({a_dr, a_di, b_dr, b_di}), 0);
        repeat (3) step_idle();
        rst_n = 1'b1;
        cnt_dv = 0;
        for (int j = 0; j < 12; j++) begin
            step_idle();
            cnt_dv += int'(a_dv) + int'(b_dv);
        end
        chk("post_rst_quiet", cnt_dv, 0);

        // samples before any sync are discarded
        cnt_dv = 0;
        for (int j = 0; j < 18; j++) begin
            if (j < 7) step(1'b1, 1'b0, rnd_sample(), rnd_sample());
            else step_idle();
            cnt_dv += int'(a_dv) + int'(b_dv);
        end
        chk("presync_quiet", cnt_dv, 0);

        // randomized traffic with sparse syncs and dv gaps
        step(1'b1, 1'b1, rnd_sample(), rnd_sample());
        for (int j = 0; j < 400; j++) begin
            logic dv, sy;
            dv = ($urandom_range(0, 3) != 0);
            sy = dv && ($urandom_range(0, 11) == 0);
            step(dv, sy, rnd_sample(), rnd_sample());
        end
        repeat (12) step_idle();
        chk("sb_drain", longint'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
